divider: RTL
============

# divider

Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, giving an 8-bit quotient and an 8-bit remainder. It is the inverse datapath of the shift-add `multiplier` and shares its load/step/ready protocol, one quotient bit per cycle. It sits beside `multiplier` in the arithmetic examples and is verified standalone and in a multiply-then-divide round trip.

## Interface
- Parameters: none; widths are fixed by package constants.
- `clk`  input  1  clock. Single clock domain.
- `rst`  input  1  reset. Synchronous, active-high.
- `in_a`  input  16  dividend; sampled when `in_vld` is high.
- `in_b`  input  8  divisor; sampled when `in_vld` is high.
- `in_vld`  input  1  load strobe; starts a new division.
- `quo`  output  8  quotient.
- `rem`  output  8  remainder.
- `err`  output  1  divide-by-zero or quotient overflow for the current result.
- `res_rdy`  output  1  result valid.

## Operation
- State: divisor `d[7:0]`, partial remainder `r[7:0]`, dividend shift register `q[7:0]` (becomes the quotient), step counter `i[3:0]`, error flag `e`.
- Priority on each rising edge: `rst` > `in_vld` > step.
- Reset sets `d=0`, `r=0`, `q=0`, `e=0`, `i=8`. Outputs after reset are `quo=0`, `rem=0`, `err=0`, `res_rdy=1`.
- Load with `in_vld`:
  - If `in_b==0` or `in_a[15:8] >= in_b`: `e=1`, `q=8'hFF`, `r=8'hFF`, `i=8`. No iterations run.
  - Otherwise: `d=in_b`, `r=in_a[15:8]`, `q=in_a[7:0]`, `e=0`, `i=0`.
- Step, taken when `i<8` and neither `rst` nor `in_vld` is high:
  - Form 9-bit `t = {r, q[7]}`.
  - If `t >= {1'b0,d}`: `r = (t - d)[7:0]`, `q = {q[6:0],1'b1}`.
  - Else: `r = t[7:0]`, `q = {q[6:0],1'b0}`.
  - Then `i = i+1`.
- Width rules:
  - `t` must be 9 bits, because the shifted remainder can reach 2·d−1.
  - The invariant `r < d` holds after load and after every step.
- Idle when `i==8`: all state holds.
- Outputs are combinational from state: `quo=q`, `rem=r`, `err=e`, `res_rdy=(i==8)`.

## Timing
- `in_vld` sampled at edge k with a legal divisor:
  - `res_rdy` falls after edge k.
  - Steps run on edges k+1..k+8.
  - `res_rdy` is high after edge k+8, so latency is 8 cycles from the load edge.
- Error load at edge k: `res_rdy=1` and `err=1` immediately after edge k.
- `in_vld` during a division aborts it and restarts with the new operands. No partial result is ever flagged ready.
- `in_vld` held high continuously reloads every cycle. `res_rdy` stays low for a legal divisor.
- `rst` mid-division returns to reset values at that edge.
- `in_vld` and `rst` high together: reset wins.
- While `res_rdy` is high, `quo`/`rem`/`err` stay stable until the next load or reset.

## Structure
- Shared package `divider_pkg`:
  - `DIVIDEND_W=16`, `DIVISOR_W=8`, `STEPS=8`.
  - `typedef logic [7:0] byte_t`.
  - Error fill constant `ERR_FILL=8'hFF`.
- One `always_ff` block: load/step. One `always_comb` block: outputs.
- The compare/subtract is a local function. A sub-module is not warranted.

## Test plan
- Reset, then idle → `res_rdy=1`, `quo=0`, `rem=0`, `err=0`.
- `in_a=16'd200`, `in_b=8'd7` → 8 cycles later `res_rdy=1`, `quo=28`, `rem=4`, `err=0`.
- `in_a=16'hFEFF`, `in_b=8'hFF` → `quo=255`, `rem=254`. Then `in_a=16'h0100`, `in_b=8'h01` → `err=1`, `quo=8'hFF`, `rem=8'hFF`, `res_rdy=1` on the next cycle. Then `in_b=0` → `err=1`.
- Load 1000/10, then reload 77/5 at cycle 3 → `res_rdy` stays low until 8 cycles after the reload, then `quo=15`, `rem=2`. `rst` at cycle 4 of a division → reset outputs on the next cycle.
- Round trip, 1000 random pairs with `b≠0`: drive `multiplier` with (a,b), feed `res` and `b` into the divider → `quo==a`, `rem==0`, `err==0`. Random dividends are also checked against the `/` and `%` reference model.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared widths, types and constants for the sequential restoring divider.
package divider_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int STEPS      = 8;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] cnt_t;

  localparam byte_t ERR_FILL = 8'hFF;
  localparam cnt_t  STEPS_C  = cnt_t'(STEPS);
endpackage

// File: rtl/divider_if.sv
// Operand/result bundle for the divider; the block drives the slave side.
interface divider_if;
  import divider_pkg::*;

  logic [DIVIDEND_W-1:0] in_a;
  byte_t                 in_b;
  logic                  in_vld;
  byte_t                 quo;
  byte_t                 rem;
  logic                  err;
  logic                  res_rdy;

  modport master (output in_a, in_b, in_vld, input quo, rem, err, res_rdy);
  modport slave  (input in_a, in_b, in_vld, output quo, rem, err, res_rdy);
endinterface

// File: rtl/divider.sv
// Restoring divider, 16b / 8b -> 8b quotient + 8b remainder, one quotient bit per cycle.
module divider
  import divider_pkg::*;
(
  input  logic clk,
  input  logic rst,
  divider_if.slave bus
);

  byte_t d_q, r_q, q_q;
  cnt_t  i_q;
  logic  e_q;

  byte_t r_d, q_d;
  logic  load_bad;

  // One restoring step; t is 9 bits since {r, q[7]} can reach 2*d-1.
  function automatic logic [15:0] div_step(byte_t r, byte_t q, byte_t d);
    logic [8:0] t;
    t = {r, q[7]};
    if (t >= {1'b0, d}) begin
      t = t - {1'b0, d};
      return {t[7:0], q[6:0], 1'b1};
    end
    return {t[7:0], q[6:0], 1'b0};
  endfunction

  assign {r_d, q_d} = div_step(r_q, q_q, d_q);
  assign load_bad   = (bus.in_b == '0) || (bus.in_a[15:8] >= bus.in_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      r_q <= '0;
      q_q <= '0;
      e_q <= 1'b0;
      i_q <= STEPS_C;
    end else if (bus.in_vld) begin
      if (load_bad) begin
        e_q <= 1'b1;
        q_q <= ERR_FILL;
        r_q <= ERR_FILL;
        i_q <= STEPS_C;
      end else begin
        d_q <= bus.in_b;
        r_q <= bus.in_a[15:8];
        q_q <= bus.in_a[7:0];
        e_q <= 1'b0;
        i_q <= '0;
      end
    end else if (i_q < STEPS_C) begin
      r_q <= r_d;
      q_q <= q_d;
      i_q <= i_q + cnt_t'(1);
    end
  end

  always_comb begin
    bus.quo     = q_q;
    bus.rem     = r_q;
    bus.err     = e_q;
    bus.res_rdy = (i_q == STEPS_C);
  end

endmodule
